// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_pkg
//  Description : Shared definitions for the AXI4 slave memory model.
//                Holds the AXI response codes, the write and read engine
//                state encodings, and helpers that derive the byte-lane
//                count and byte-offset width from the data bus width.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Number of byte lanes on a data bus of the given width.
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    // Number of low address bits that select a byte inside one bus word.
    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_be_array.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_be_array
//  Description : Word-addressed storage with one byte-enabled synchronous
//                write port and one asynchronous read port.
//                A read of the word being written in the same cycle returns
//                the pre-write contents. Contents are never reset.
//  Ports       : clk            clock
//                we             write enable
//                waddr/wdata    write word index / write data
//                wstrb          per-byte write enables
//                raddr/rdata    read word index / combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_be_array #(
    parameter  int DATA_WIDTH = 64,
    parameter  int WORDS      = 1024,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // One independent storage array per byte lane keeps every lane's write
    // process the sole driver of its own storage.
    for (genvar b = 0; b < BYTES; b++) begin : g_lane
        logic [7:0] r_mem [WORDS];

        always_ff @(posedge clk) begin
            if (we && wstrb[b]) begin
                r_mem[waddr] <= wdata[b*8 +: 8];
            end
        end

        assign rdata[b*8 +: 8] = r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem
//  Description : AXI4 slave memory model terminating AW/W/B/AR/R into a
//                word-addressed array. Independent write and read engines,
//                one outstanding burst per direction, full-width INCR only.
//                Word index = addr[OFFSET_BITS +: log2(MEM_WORDS)], wrapping.
//  Ports       : clk, rst_n (synchronous, active-low; all outputs 0 while low)
//                axi_aw_* / axi_w_* / axi_b_*   write address, data, response
//                axi_ar_* / axi_r_*             read address, data
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_mem
    import axi_mem_pkg::*;
#(
    parameter  int AXI_DATA_WIDTH = 64,
    parameter  int AXI_ADDR_WIDTH = 64,
    parameter  int AXI_ID_WIDTH   = 4,
    parameter  int MEM_WORDS      = 1024,
    localparam int BYTES          = bytes_of(AXI_DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ID_WIDTH-1:0]   axi_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_i,
    input  logic [7:0]                axi_aw_len_i,
    input  logic                      axi_aw_valid_i,
    output logic                      axi_aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] axi_w_data_i,
    input  logic [BYTES-1:0]          axi_w_strb_i,
    input  logic                      axi_w_last_i,
    input  logic                      axi_w_valid_i,
    output logic                      axi_w_ready_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_b_id_o,
    output logic [1:0]                axi_b_resp_o,
    output logic                      axi_b_valid_o,
    input  logic                      axi_b_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_i,
    input  logic [7:0]                axi_ar_len_i,
    input  logic                      axi_ar_valid_i,
    output logic                      axi_ar_ready_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_r_id_o,
    output logic [AXI_DATA_WIDTH-1:0] axi_r_data_o,
    output logic [1:0]                axi_r_resp_o,
    output logic                      axi_r_last_o,
    output logic                      axi_r_valid_o,
    input  logic                      axi_r_ready_i
);

    localparam int OFFSET_BITS = offset_bits(AXI_DATA_WIDTH);
    localparam int IDX_W       = $clog2(MEM_WORDS);

    wr_state_e                r_wr_state, w_wr_state_next;
    logic [AXI_ID_WIDTH-1:0]  r_wr_id;
    logic [IDX_W-1:0]         r_wr_idx;
    logic [7:0]               r_wr_cnt;
    logic                     r_wr_err;

    rd_state_e                r_rd_state, w_rd_state_next;
    logic [AXI_ID_WIDTH-1:0]  r_rd_id;
    logic [IDX_W-1:0]         r_rd_idx;
    logic [7:0]               r_rd_cnt;

    logic                      w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [AXI_DATA_WIDTH-1:0] w_rd_word;
    logic                      w_unused_addr;

    // Offset bits and bits above the index are don't-care by design.
    assign w_unused_addr = ^{axi_aw_addr_i, axi_ar_addr_i};

    assign w_aw_hs = axi_aw_valid_i && axi_aw_ready_o;
    assign w_w_hs  = axi_w_valid_i  && axi_w_ready_o;
    assign w_b_hs  = axi_b_valid_o  && axi_b_ready_i;
    assign w_ar_hs = axi_ar_valid_i && axi_ar_ready_o;
    assign w_r_hs  = axi_r_valid_o  && axi_r_ready_i;

    axi_mem_be_array #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .WORDS      (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (w_w_hs),
        .waddr (r_wr_idx),
        .wdata (axi_w_data_i),
        .wstrb (axi_w_strb_i),
        .raddr (r_rd_idx),
        .rdata (w_rd_word)
    );

    // ---------------------------------------------------------------- write
    always_ff @(posedge clk) begin
        if (!rst_n) r_wr_state <= W_IDLE;
        else        r_wr_state <= w_wr_state_next;
    end

    // Outputs are qualified by rst_n so the interface is silent during reset
    // even before the state register has been cleared.
    always_comb begin
        w_wr_state_next = r_wr_state;
        axi_aw_ready_o  = 1'b0;
        axi_w_ready_o   = 1'b0;
        axi_b_valid_o   = 1'b0;
        axi_b_id_o      = '0;
        axi_b_resp_o    = RESP_OKAY;
        if (rst_n) begin
            case (r_wr_state)
                W_IDLE: begin
                    axi_aw_ready_o = 1'b1;
                    if (axi_aw_valid_i) w_wr_state_next = W_DATA;
                end
                W_DATA: begin
                    axi_w_ready_o = 1'b1;
                    if (axi_w_valid_i && (r_wr_cnt == 8'd0)) w_wr_state_next = W_RESP;
                end
                W_RESP: begin
                    axi_b_valid_o = 1'b1;
                    axi_b_id_o    = r_wr_id;
                    axi_b_resp_o  = r_wr_err ? RESP_SLVERR : RESP_OKAY;
                    if (axi_b_ready_i) w_wr_state_next = W_IDLE;
                end
                default: w_wr_state_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_id  <= '0;
            r_wr_idx <= '0;
            r_wr_cnt <= '0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_wr_id  <= axi_aw_id_i;
                r_wr_idx <= axi_aw_addr_i[OFFSET_BITS +: IDX_W];
                r_wr_cnt <= axi_aw_len_i;
            end
            if (w_w_hs) begin
                r_wr_idx <= r_wr_idx + 1'b1;
                // Burst length follows aw_len; a misplaced w_last only flags.
                if (r_wr_cnt != 8'd0) r_wr_cnt <= r_wr_cnt - 8'd1;
                if (axi_w_last_i != (r_wr_cnt == 8'd0)) r_wr_err <= 1'b1;
            end
            if (w_b_hs) r_wr_err <= 1'b0;
        end
    end

    // ----------------------------------------------------------------- read
    always_ff @(posedge clk) begin
        if (!rst_n) r_rd_state <= R_IDLE;
        else        r_rd_state <= w_rd_state_next;
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        axi_ar_ready_o  = 1'b0;
        axi_r_valid_o   = 1'b0;
        axi_r_id_o      = '0;
        axi_r_data_o    = '0;
        axi_r_last_o    = 1'b0;
        axi_r_resp_o    = RESP_OKAY;
        if (rst_n) begin
            case (r_rd_state)
                R_IDLE: begin
                    axi_ar_ready_o = 1'b1;
                    if (axi_ar_valid_i) w_rd_state_next = R_DATA;
                end
                R_DATA: begin
                    axi_r_valid_o = 1'b1;
                    axi_r_id_o    = r_rd_id;
                    axi_r_data_o  = w_rd_word;
                    axi_r_last_o  = (r_rd_cnt == 8'd0);
                    if (axi_r_ready_i && (r_rd_cnt == 8'd0)) w_rd_state_next = R_IDLE;
                end
                default: w_rd_state_next = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_id  <= '0;
            r_rd_idx <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rd_id  <= axi_ar_id_i;
                r_rd_idx <= axi_ar_addr_i[OFFSET_BITS +: IDX_W];
                r_rd_cnt <= axi_ar_len_i;
            end
            if (w_r_hs && (r_rd_cnt != 8'd0)) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                r_rd_cnt <= r_rd_cnt - 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
